ir_nec_rx: RTL and testbench

IR_NEC_RX -- requirements
Module: ir_nec_rx

---
 rtl/ir_pkg.sv | 49 ++++
 rtl/ir_tick_gen.sv | 31 +++
 rtl/ir_nec_rx.sv | 185 ++++++++++++++++++
 tb/tb_ir_nec_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_pkg
// Purpose  : Shared types and pulse-width windows (in us) for the NEC
//            IR receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ir_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4
  } state_t;

  // Leader burst and the two possible leader spaces (frame / repeat)
  localparam logic [15:0] LEAD_MARK_MIN  = 16'd8000;
  localparam logic [15:0] LEAD_MARK_MAX  = 16'd10000;
  localparam logic [15:0] LEAD_SPACE_MIN = 16'd3500;
  localparam logic [15:0] LEAD_SPACE_MAX = 16'd5500;
  localparam logic [15:0] REP_SPACE_MIN  = 16'd1750;
  localparam logic [15:0] REP_SPACE_MAX  = 16'd2750;

  // Data bit burst and the space that encodes the bit value
  localparam logic [15:0] BIT_MARK_MIN   = 16'd300;
  localparam logic [15:0] BIT_MARK_MAX   = 16'd800;
  localparam logic [15:0] BIT0_MIN       = 16'd300;
  localparam logic [15:0] BIT0_MAX       = 16'd800;
  localparam logic [15:0] BIT1_MIN       = 16'd1300;
  localparam logic [15:0] BIT1_MAX       = 16'd2000;

  function automatic logic in_window(input logic [15:0] w,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // Complement checks on the command and/or address byte pairs
  function automatic logic frame_ok(input logic [31:0] d,
                                    input logic        chk_cmd,
                                    input logic        chk_addr);
    return (!chk_cmd  || (d[31:24] == ~d[23:16])) &&
           (!chk_addr || (d[15:8]  == ~d[7:0]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : ir_tick_gen
// Purpose  : Free-running divider producing a one-cycle tick every CLK_DIV
//            clocks (1 us timebase). Used as an enable, never as a clock.
// Revision : 1.0 - initial release
// ============================================================================
module ir_tick_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLK_DIV-1 and wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else                      cnt <= cnt + CNT_W'(1);
  end

  assign o_tick = (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/ir_nec_rx.sv
`default_nettype none
// ============================================================================
// Module   : ir_nec_rx
// Purpose  : NEC IR frame decoder. Measures mark/space widths in us and
//            walks leader -> 32 data bits, with repeat-code support and
//            optional command/address complement checks.
// Revision : 1.0 - initial release
// ============================================================================
module ir_nec_rx
  import ir_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int TIMEOUT_US = 12000,
  parameter int CHECK_CMD  = 1,
  parameter int CHECK_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ir_rxb,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_repeat,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_US);
  localparam logic        CMD_EN    = (CHECK_CMD != 0);
  localparam logic        ADDR_EN   = (CHECK_ADDR != 0);

  logic        sync_1, sync_2, mark_d;
  logic        mark, mark_rise, mark_fall, mark_edge, tick;
  logic [15:0] width;
  state_t      state, state_nx;
  logic [31:0] shift, shift_nx, data_nx, frame;
  logic [5:0]  bit_cnt, bit_cnt_nx;
  logic        accepted, accepted_nx;
  logic        valid_nx, repeat_nx, err_nx, bit_val;

  ir_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (tick)
  );

  // Synchronise the inverted receiver output; flops hold mark polarity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      mark_d <= 1'b0;
    end else begin
      sync_1 <= ~i_ir_rxb;
      sync_2 <= sync_1;
      mark_d <= sync_2;
    end
  end

  assign mark      = sync_2;
  assign mark_rise = mark & ~mark_d;
  assign mark_fall = ~mark & mark_d;
  assign mark_edge = mark_rise | mark_fall;
  assign o_busy    = (state != IDLE);

  // Level width in us; edge wins over a coincident tick (old value is classified)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         width <= 16'd0;
    else if (mark_edge)                 width <= 16'd0;
    else if (tick && width != 16'hFFFF) width <= width + 16'd1;
  end

  // Decoder next-state and pulse generation
  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    bit_cnt_nx  = bit_cnt;
    accepted_nx = accepted;
    data_nx     = o_data;
    valid_nx    = 1'b0;
    repeat_nx   = 1'b0;
    err_nx      = 1'b0;
    bit_val     = (width >= BIT1_MIN);
    frame       = {bit_val, shift[31:1]};

    case (state)
      IDLE: begin
        if (mark_rise) state_nx = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (mark_fall) begin
          if (in_window(width, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
            state_nx = LEAD_SPACE;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      LEAD_SPACE: begin
        if (mark_rise) begin
          if (in_window(width, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_nx   = BIT_MARK;
            bit_cnt_nx = 6'd0;
          end else if (in_window(width, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            repeat_nx = accepted;
            err_nx    = ~accepted;
            state_nx  = IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      BIT_MARK: begin
        if (mark_fall) begin
          if (in_window(width, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            state_nx = BIT_SPACE;
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      BIT_SPACE: begin
        if (mark_rise) begin
          if (in_window(width, BIT0_MIN, BIT0_MAX) ||
              in_window(width, BIT1_MIN, BIT1_MAX)) begin
            shift_nx   = frame;
            bit_cnt_nx = bit_cnt + 6'd1;
            if (bit_cnt == 6'd31) begin
              // This rising edge is also the stop burst; IDLE ignores its fall
              state_nx = IDLE;
              if (frame_ok(frame, CMD_EN, ADDR_EN)) begin
                valid_nx    = 1'b1;
                data_nx     = frame;
                accepted_nx = 1'b1;
              end else begin
                err_nx = 1'b1;
              end
            end else begin
              state_nx = BIT_MARK;
            end
          end else begin
            err_nx   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // A level held too long inside a frame aborts it
    if (state != IDLE && !mark_edge && width >= TIMEOUT_W) begin
      state_nx  = IDLE;
      err_nx    = 1'b1;
      valid_nx  = 1'b0;
      repeat_nx = 1'b0;
    end
  end

  // Decoder state and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= 32'd0;
      bit_cnt  <= 6'd0;
      accepted <= 1'b0;
      o_data   <= 32'd0;
      o_valid  <= 1'b0;
      o_repeat <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      state    <= state_nx;
      shift    <= shift_nx;
      bit_cnt  <= bit_cnt_nx;
      accepted <= accepted_nx;
      o_data   <= data_nx;
      o_valid  <= valid_nx;
      o_repeat <= repeat_nx;
      o_err    <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_nec_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_nec_rx
// Purpose  : Randomised NEC waveform stimulus for two receiver instances
//            (command check only / address check only) with a queued
//            scoreboard of expected output events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_nec_rx;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_rxb;
  logic [31:0] data_a, data_b;
  logic        valid_a, repeat_a, err_a, busy_a;
  logic        valid_b, repeat_b, err_b, busy_b;

  always #5 clk = ~clk;

  ir_nec_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_US(12000), .CHECK_CMD(1), .CHECK_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir_rxb), .o_data(data_a),
    .o_valid(valid_a), .o_repeat(repeat_a), .o_err(err_a), .o_busy(busy_a));

  ir_nec_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_US(12000), .CHECK_CMD(0), .CHECK_ADDR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_ir_rxb(ir_rxb), .o_data(data_b),
    .o_valid(valid_b), .o_repeat(repeat_b), .o_err(err_b), .o_busy(busy_b));

  typedef enum int {EV_VALID, EV_REPEAT, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [31:0] data;
  } ev_t;

  ev_t         q_a[$];
  ev_t         q_b[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_data [2];
  bit          exp_acc  [2];

  // ---------------- reference model ----------------
  function automatic bit rules_ok(input int i, input logic [31:0] d);
    bit cmd_ok, addr_ok;
    cmd_ok  = ((d[31:24] ^ d[23:16]) == 8'hFF);
    addr_ok = ((d[15:8]  ^ d[7:0])   == 8'hFF);
    if (i == 0) return cmd_ok;
    return addr_ok;
  endfunction

  task automatic push(input int i, input ev_kind_t k);
    ev_t e;
    e.kind = k;
    e.data = exp_data[i];
    if (i == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic model_frame(input logic [31:0] d);
    for (int i = 0; i < 2; i++) begin
      if (rules_ok(i, d)) begin
        exp_data[i] = d;
        exp_acc[i]  = 1'b1;
        push(i, EV_VALID);
      end else begin
        push(i, EV_ERR);
      end
    end
  endtask

  task automatic model_repeat();
    for (int i = 0; i < 2; i++) push(i, exp_acc[i] ? EV_REPEAT : EV_ERR);
  endtask

  task automatic model_err();
    for (int i = 0; i < 2; i++) push(i, EV_ERR);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_data[i] = 32'd0;
      exp_acc[i]  = 1'b0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic v, input logic r, input logic e,
                     input logic [31:0] d);
    ev_t      ex;
    ev_kind_t got;
    int       npulse;
    npulse = int'(v) + int'(r) + int'(e);
    if (npulse == 0) return;
    checks++;
    if (npulse > 1) begin
      errors++;
      $display("FAIL exclusive_%0d: valid=%b repeat=%b err=%b, required one-hot", i, v, r, e);
      return;
    end
    got = v ? EV_VALID : (r ? EV_REPEAT : EV_ERR);
    if ((i == 0 && q_a.size() == 0) || (i == 1 && q_b.size() == 0)) begin
      errors++;
      $display("FAIL unexpected_%0d: got event %s data %h, required none", i, got.name(), d);
      return;
    end
    ex = (i == 0) ? q_a.pop_front() : q_b.pop_front();
    if (got != ex.kind || d !== ex.data) begin
      errors++;
      $display("FAIL event_%0d: got %s data %h, required %s data %h",
               i, got.name(), d, ex.kind.name(), ex.data);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever a DUT pulses
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0, valid_a, repeat_a, err_a, data_a);
      mon(1, valid_b, repeat_b, err_b, data_b);
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending a=%0d b=%0d, required 0", name, q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
    @(negedge clk);
    chk({name, "_data_a"}, data_a, exp_data[0]);
    chk({name, "_data_b"}, data_b, exp_data[1]);
  endtask

  // ---------------- stimulus ----------------
  task automatic hold(input bit m, input int us);
    ir_rxb = ~m;
    repeat (us * CLK_DIV) @(negedge clk);
  endtask

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic send_lead(input int mark_us, input int space_us);
    hold(1'b1, mark_us);
    hold(1'b0, space_us);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, rnd(320, 450));
      hold(1'b0, d[i] ? rnd(1320, 1500) : rnd(320, 450));
    end
  endtask

  task automatic send_frame(input string name, input logic [31:0] d);
    send_lead(rnd(8050, 8400), rnd(3550, 3900));
    send_bits(d, 32);
    model_frame(d);                 // decided on the stop burst rising edge
    hold(1'b1, rnd(320, 450));
    hold(1'b0, 600);
    wait_drain(name);
  endtask

  task automatic send_repeat(input string name);
    send_lead(rnd(8050, 8400), rnd(2000, 2400));
    model_repeat();
    hold(1'b1, rnd(320, 450));
    hold(1'b0, 600);
    wait_drain(name);
  endtask

  function automatic logic [31:0] good_word();
    logic [7:0] c, a;
    c = 8'($urandom);
    a = 8'($urandom);
    return {~c, c, ~a, a};
  endfunction

  initial begin
    rst_n  = 1'b0;
    ir_rxb = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);

    // Reset state
    chk("reset_data_a",  data_a, 32'd0);
    chk("reset_flags_a", {valid_a, repeat_a, err_a, busy_a}, 32'd0);
    chk("reset_data_b",  data_b, 32'd0);
    chk("reset_flags_b", {valid_b, repeat_b, err_b, busy_b}, 32'd0);
    rst_n = 1'b1;
    hold(1'b0, 200);

    // Repeat code before any accepted frame is an error
    send_repeat("repeat_after_reset");

    // Reference frame, then a repeat of it
    send_frame("frame_ba45ff00", 32'hBA45FF00);
    send_repeat("repeat_after_frame");

    // Command inverse wrong: rejected by the command check, accepted otherwise
    send_frame("frame_0045ff00", 32'h0045FF00);

    // Short leader burst
    hold(1'b1, 6000);
    model_err();
    hold(1'b0, 600);
    wait_drain("short_lead");
    send_frame("frame_after_short_lead", good_word());

    // Unconstrained random payload
    send_frame("frame_random", $urandom);

    // Mark frozen after 10 bits
    send_lead(rnd(8050, 8400), rnd(3550, 3900));
    send_bits($urandom, 10);
    chk("busy_in_frame", busy_a, 32'd1);
    model_err();
    hold(1'b1, 13000);
    chk("timeout_before_release", q_a.size() + q_b.size(), 32'd0);
    chk("busy_after_timeout_a", busy_a, 32'd0);
    chk("busy_after_timeout_b", busy_b, 32'd0);
    hold(1'b0, 600);
    wait_drain("timeout");

    // Reset in the middle of a frame (during a space after bit 16)
    send_lead(rnd(8050, 8400), rnd(3550, 3900));
    send_bits($urandom, 16);
    hold(1'b0, 100);
    rst_n = 1'b0;
    #1;
    chk("midreset_data_a",  data_a, 32'd0);
    chk("midreset_flags_a", {valid_a, repeat_a, err_a, busy_a}, 32'd0);
    chk("midreset_data_b",  data_b, 32'd0);
    chk("midreset_flags_b", {valid_b, repeat_b, err_b, busy_b}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 500);
    wait_drain("after_midreset");
    send_frame("frame_after_midreset", good_word());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
